// File: rtl/cable_delay_pipe_if.sv
// Cable delay pipe signal bundle.
// Config, input strobes and delayed outputs.
interface cable_delay_pipe_if;
  logic [7:0] CABLEDLY;
  logic [3:0] L1FDLY;
  logic [2:0] KILLINPUT;
  logic [4:0] LCT_IN;
  logic       L1A_IN;
  logic [4:0] LCT_DLY;
  logic       L1A_DLY;
  logic       BUSY;
  logic [7:0] DROP_CNT;

  modport master (
    output CABLEDLY, L1FDLY, KILLINPUT,
    output LCT_IN, L1A_IN,
    input  LCT_DLY, L1A_DLY, BUSY, DROP_CNT
  );

  modport slave (
    input  CABLEDLY, L1FDLY, KILLINPUT,
    input  LCT_IN, L1A_IN,
    output LCT_DLY, L1A_DLY, BUSY, DROP_CNT
  );
endinterface

// File: rtl/cable_delay_pipe.sv
// Programmable LCT/L1A delay line.
// Circular buffer, fine L1A tap, settle window.
module cable_delay_pipe #(
  parameter int DEPTH = 256
) (
  input logic              CLKCMS,
  input logic              RST,
  cable_delay_pipe_if.slave bus
);

  typedef enum logic {IDLE, SETTLE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [8:0]  r_cnt;
  logic [8:0]  w_cnt_nxt;
  logic [7:0]  r_d;
  logic [3:0]  r_f;
  logic [7:0]  r_wptr;
  logic [7:0]  w_raddr;
  logic [5:0]  r_in;
  logic [5:0]  w_rd;
  logic [4:0]  w_kill;
  logic [14:0] r_sr;
  logic [15:0] w_chain;
  logic        w_tap;
  logic [4:0]  r_lct;
  logic        r_l1a;
  logic [7:0]  r_drop;
  logic        w_chg;
  logic        w_busy;
  logic [5:0]  r_mem [0:DEPTH-1];

  assign w_chg   = (bus.CABLEDLY != r_d) ||
                   (bus.L1FDLY != r_f);
  assign w_busy  = (r_state == SETTLE);
  assign w_raddr = r_wptr - r_d;
  // D=0 means the word being written now is the one to emit.
  assign w_rd    = (r_d == 8'd0) ? r_in
                                 : r_mem[w_raddr];
  assign w_chain = {r_sr, w_rd[5]};
  assign w_tap   = w_chain[r_f];

  // Kill mask decode; 6 and 7 kill every CFEB.
  always_comb begin
    w_kill = '0;
    priority case (1'b1)
      (bus.KILLINPUT >= 3'd6):
        w_kill = 5'h1F;
      (bus.KILLINPUT != 3'd0):
        w_kill = 5'(5'd1 << (bus.KILLINPUT - 3'd1));
      default:
        w_kill = '0;
    endcase
  end

  // Settle FSM next state and counter.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_chg) begin
          w_state_nxt = SETTLE;
          w_cnt_nxt   = '0;
        end
      end
      SETTLE: begin
        if (w_chg) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == 9'd271) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 9'd1;
        end
      end
    endcase
  end

  // Settle FSM state and config copies.
  always_ff @(posedge CLKCMS or posedge RST) begin
    if (RST) begin
      r_state <= SETTLE;
      r_cnt   <= '0;
      r_d     <= '0;
      r_f     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_d     <= bus.CABLEDLY;
      r_f     <= bus.L1FDLY;
    end
  end

  // Input capture, pointer, fine shifter, outputs.
  always_ff @(posedge CLKCMS or posedge RST) begin
    if (RST) begin
      r_wptr <= '0;
      r_in   <= '0;
      r_sr   <= '0;
      r_lct  <= '0;
      r_l1a  <= '0;
    end else begin
      r_wptr <= r_wptr + 8'd1;
      r_in   <= {bus.L1A_IN, bus.LCT_IN & ~w_kill};
      r_sr   <= {r_sr[13:0], w_rd[5]};
      r_lct  <= w_rd[4:0];
      r_l1a  <= w_tap;
    end
  end

  // Buffer needs no reset; outputs are masked while settling.
  always_ff @(posedge CLKCMS) begin
    r_mem[r_wptr] <= r_in;
  end

  // Lost L1A counter, saturating.
  always_ff @(posedge CLKCMS or posedge RST) begin
    if (RST) begin
      r_drop <= '0;
    end else if (bus.L1A_IN && w_busy &&
                 (r_drop != 8'hFF)) begin
      r_drop <= r_drop + 8'd1;
    end
  end

  assign bus.BUSY     = w_busy;
  assign bus.LCT_DLY  = w_busy ? 5'd0 : r_lct;
  assign bus.L1A_DLY  = w_busy ? 1'b0 : r_l1a;
  assign bus.DROP_CNT = r_drop;

endmodule

// File: tb/tb_cable_delay_pipe.sv
// Scoreboard bench for cable_delay_pipe.
// Expected strobes queued at drive time.
module tb_cable_delay_pipe;

  typedef struct {
    int         due;
    logic [4:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   dly = 0;
  int   fdly = 0;
  exp_t q_lct[$];
  int   q_l1a[$];

  cable_delay_pipe_if bus ();

  cable_delay_pipe #(.DEPTH(256)) dut (
    .CLKCMS (clk),
    .RST    (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic logic [4:0] kmask(input logic [2:0] k);
    if (k == 3'd0) return 5'h00;
    if (k >= 3'd6) return 5'h1F;
    return 5'(5'd1 << (k - 3'd1));
  endfunction

  always @(negedge clk) begin
    if (q_lct.size() > 0 && q_lct[0].due == cyc) begin
      chk("lct", 32'(bus.LCT_DLY), 32'(q_lct[0].v));
      void'(q_lct.pop_front());
    end else if (bus.LCT_DLY != 5'd0) begin
      chk("lct_spur", 32'(bus.LCT_DLY), 32'd0);
    end
    if (q_l1a.size() > 0 && q_l1a[0] == cyc) begin
      chk("l1a", 32'(bus.L1A_DLY), 32'd1);
      void'(q_l1a.pop_front());
    end else if (bus.L1A_DLY != 1'b0) begin
      chk("l1a_spur", 32'(bus.L1A_DLY), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int d, input int f);
    bus.CABLEDLY = 8'(d);
    bus.L1FDLY   = 4'(f);
    dly  = d;
    fdly = f;
  endtask

  task automatic drive(input logic [4:0] l, input logic a);
    logic [4:0] m;
    bus.LCT_IN = l;
    bus.L1A_IN = a;
    m = l & ~kmask(bus.KILLINPUT);
    if (m != 5'd0) q_lct.push_back('{cyc + dly + 2, m});
    if (a) q_l1a.push_back(cyc + dly + fdly + 2);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.BUSY && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) chk("idle_timeout", 32'(n), 32'd0);
  endtask

  task automatic settle_to(input int d, input int f);
    set_cfg(d, f);
    tick();
    tick();
    wait_idle();
  endtask

  task automatic measure_busy(output int n);
    int g = 0;
    n = 0;
    while (g < 3000) begin
      @(negedge clk);
      if (bus.BUSY) n++;
      else if (n > 0) break;
      g++;
    end
    if (g >= 3000) chk("busy_timeout", 32'(g), 32'd0);
    tick();
  endtask

  task automatic chk_drained(input string tag);
    chk({tag, "_lctq"}, 32'(q_lct.size()), 32'd0);
    chk({tag, "_l1aq"}, 32'(q_l1a.size()), 32'd0);
  endtask

  initial begin
    int   n;
    int   d0;
    logic any_busy;
    logic [2:0] ks [3];
    logic [4:0] pat_l [4];
    logic       pat_a [4];
    ks = '{3'd0, 3'd3, 3'd6};
    pat_l = '{5'h01, 5'h1F, 5'h00, 5'h0A};
    pat_a = '{1'b1, 1'b1, 1'b0, 1'b1};

    set_cfg(0, 0);
    bus.KILLINPUT = 3'd0;
    bus.LCT_IN = '0;
    bus.L1A_IN = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.BUSY), 32'd1);
    chk("rst_drop", 32'(bus.DROP_CNT), 32'd0);
    chk("rst_lct", 32'(bus.LCT_DLY), 32'd0);
    chk("rst_l1a", 32'(bus.L1A_DLY), 32'd0);
    tick();
    rst = 1'b0;
    measure_busy(n);
    chk("rst_busy_len", 32'(n), 32'd272);

    for (int i = 0; i < 4; i++) begin
      drive(pat_l[i], pat_a[i]);
      tick();
    end
    drive(5'd0, 1'b0);
    repeat (10) tick();
    chk_drained("d0f0");

    set_cfg(10, 3);
    @(negedge clk);
    chk("busy_pre10", 32'(bus.BUSY), 32'd0);
    measure_busy(n);
    chk("busy_len10", 32'(n), 32'd272);
    drive(5'h01, 1'b1);
    tick();
    drive(5'd0, 1'b0);
    repeat (20) tick();
    chk_drained("lat");

    d0 = int'(bus.DROP_CNT);
    n = 0;
    set_cfg(20, 3);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (i == 0) chk("busy_pre", 32'(bus.BUSY), 32'd0);
      if (i == 1) chk("busy_rise", 32'(bus.BUSY), 32'd1);
      if (bus.BUSY) n++;
      tick();
      bus.L1A_IN = (i + 1 == 50) || (i + 1 == 60) ||
                   (i + 1 == 70);
      if (i + 1 == 100) set_cfg(21, 3);
    end
    chk("busy_ext", 32'(n), 32'd372);
    chk("drop3", 32'(bus.DROP_CNT), 32'(d0 + 3));
    chk_drained("settle");

    any_busy = 1'b0;
    for (int s = 0; s < 3; s++) begin
      bus.KILLINPUT = ks[s];
      for (int j = 0; j < 30; j++) begin
        drive(5'h1F, j == 5);
        tick();
        any_busy |= bus.BUSY;
      end
    end
    drive(5'd0, 1'b0);
    bus.KILLINPUT = 3'd0;
    repeat (40) begin
      tick();
      any_busy |= bus.BUSY;
    end
    chk("kill_busy", 32'(any_busy), 32'd0);
    chk_drained("kill");

    settle_to(255, 15);
    for (int i = 0; i < 3; i++) begin
      drive(5'h04, 1'b1);
      tick();
    end
    drive(5'd0, 1'b0);
    repeat (300) tick();
    chk_drained("wrap");

    settle_to(0, 0);
    drive(5'h10, 1'b1);
    tick();
    drive(5'd0, 1'b0);
    repeat (5) tick();
    chk_drained("min");

    d0 = int'(bus.DROP_CNT);
    set_cfg(1, 0);
    for (int i = 0; i < 250; i++) begin
      tick();
      bus.L1A_IN = 1'b1;
    end
    tick();
    bus.L1A_IN = 1'b0;
    chk("drop_part", 32'(bus.DROP_CNT), 32'(d0 + 250));
    set_cfg(0, 0);
    for (int i = 0; i < 60; i++) begin
      tick();
      bus.L1A_IN = 1'b1;
    end
    tick();
    bus.L1A_IN = 1'b0;
    chk("drop_sat", 32'(bus.DROP_CNT), 32'hFF);
    wait_idle();
    set_cfg(1, 0);
    tick();
    repeat (5) begin
      tick();
      bus.L1A_IN = 1'b1;
    end
    tick();
    bus.L1A_IN = 1'b0;
    chk("drop_hold", 32'(bus.DROP_CNT), 32'hFF);
    wait_idle();
    chk_drained("sat");

    settle_to(30, 5);
    for (int i = 0; i < 40; i++) begin
      drive(5'h1F, 1'b1);
      tick();
    end
    @(negedge clk);
    chk("pre_rst_lct", 32'(bus.LCT_DLY), 32'h1F);
    #2;
    rst = 1'b1;
    bus.LCT_IN = '0;
    bus.L1A_IN = 1'b0;
    q_lct.delete();
    q_l1a.delete();
    #1;
    chk("arst_lct", 32'(bus.LCT_DLY), 32'd0);
    chk("arst_l1a", 32'(bus.L1A_DLY), 32'd0);
    chk("arst_busy", 32'(bus.BUSY), 32'd1);
    chk("arst_drop", 32'(bus.DROP_CNT), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    wait_idle();
    repeat (300) tick();
    chk_drained("post_rst");

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cable_delay_pipe.md
CABLE_DELAY_PIPE -- requirements
Module: cable_delay_pipe

Interface
REQ-001 Parameter: DEPTH, default 256, buffer depth in words; fixed at 256 because CABLEDLY is 8 bits wide.
REQ-002 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-003 CLKCMS  in  1  system clock; all state changes on its rising edge.
REQ-004 RST  in  1  asynchronous active-high reset.
REQ-005 CABLEDLY  in  8  coarse cable delay D, from the serial flash config block.
REQ-006 L1FDLY  in  4  extra L1A fine delay F, from the serial flash config block.
REQ-007 KILLINPUT  in  3  kill code K, from the serial flash config block.
REQ-008 LCT_IN  in  5  per-CFEB LCT strobes.
REQ-009 L1A_IN  in  1  L1A strobe.
REQ-010 LCT_DLY  out  5  delayed, masked LCT strobes.
REQ-011 L1A_DLY  out  1  delayed L1A strobe.
REQ-012 BUSY  out  1  settle window active; delayed outputs forced low.
REQ-013 DROP_CNT  out  8  count of L1A_IN pulses lost during BUSY; saturates at 8'hFF.

Function
REQ-014 Input stage: one register captures {L1A_IN, LCT_IN & ~kill_mask} every cycle.
REQ-015 Kill mask from K: 0 = none; 1..5 = kill LCT_IN[K-1] only; 6 and 7 = kill all five bits. The mask never applies to L1A.
REQ-016 Buffer: 256 x 6 circular buffer.
  - Written every cycle at wptr with the input-stage word.
  - wptr increments by 1 every cycle and wraps 255 -> 0.
REQ-017 Read: the buffer is read every cycle at raddr = (wptr - D) mod 256, using 8-bit wrap arithmetic.
REQ-018 LCT latency: LCT_DLY at cycle t = masked LCT_IN at cycle t-(D+2), registered output. D=0 gives 2 cycles; D=255 gives 257 cycles.
REQ-019 L1A latency: the L1A bit read from the buffer passes a 16-stage shift register tapped at F.
  - F=0 bypasses the shift register.
  - L1A_DLY at cycle t = L1A_IN at cycle t-(D+F+2).
  - Range 2..272 cycles.
REQ-020 Settle state machine, 2 states:
  - IDLE -> SETTLE on reset release, or when CABLEDLY or L1FDLY differs from its registered copy.
  - SETTLE -> IDLE when the settle counter reaches 271, i.e. 272 cycles in SETTLE.
REQ-021 Settle restart: a further CABLEDLY/L1FDLY change while in SETTLE clears the settle counter to 0 and stays in SETTLE.
REQ-022 BUSY = 1 exactly while in SETTLE. While BUSY = 1, LCT_DLY and L1A_DLY are forced 0; the buffer keeps writing.
REQ-023 Drop counting: each cycle with L1A_IN=1 and BUSY=1 increments DROP_CNT by 1, saturating at 255.
  - DROP_CNT clears only on RST.
REQ-024 Kill timing: a change of KILLINPUT does not trigger SETTLE. It applies to the next captured word, so the first affected output appears D+2 cycles later.
REQ-025 Pulse count: back-to-back strobes on consecutive cycles are reproduced cycle-for-cycle. There is no merging or dropping outside BUSY.

Reset
REQ-026 On RST=1, asynchronously:
  - wptr=0, settle counter=0, state=SETTLE, registered D/F copies=0.
  - LCT_DLY=0, L1A_DLY=0, BUSY=1, DROP_CNT=0, input stage=0, fine shift register=0.
REQ-027 After RST falls, BUSY stays 1 for 272 cycles, then falls. Buffer contents do not need resetting, because the outputs are masked during the settle window.
REQ-028 RST asserted mid-operation aborts any settle window or pending strobes. Recovery then follows REQ-027.

Verification
REQ-029 Latency check: reset, D=10, F=3, K=0; after BUSY falls, one L1A_IN and LCT_IN=5'b00001 pulse at cycle t0.
  - Required: LCT_DLY=5'b00001 at t0+12 only.
  - Required: L1A_DLY=1 at t0+15 only.
REQ-030 Wrap and extremes: D=255, F=15, a 3-cycle L1A burst -> L1A_DLY high for 3 consecutive cycles starting 272 cycles later. Then D=0, F=0 -> latency 2 after settle.
REQ-031 Delay change and settle: change D from 10 to 20.
  - BUSY rises one cycle after the change and stays high 272 cycles.
  - Injected L1A during that window: no output; DROP_CNT increments by 1 per pulse.
  - A second change at settle cycle 100 extends BUSY to 100+272 cycles from the first change.
REQ-032 Kill codes: with LCT_IN=5'b11111 constant, step K through 0,3,6.
  - Outputs: 5'b11111, 5'b11011, 5'b00000, each after D+2 cycles.
  - BUSY does not rise; L1A is unaffected.
REQ-033 DROP_CNT saturation: 300 L1A pulses during repeated settle windows -> DROP_CNT=8'hFF and holds there.
REQ-034 Async reset: assert RST mid-stream with pending strobes in the buffer.
  - Outputs go 0 immediately without waiting for a clock edge; DROP_CNT=0; BUSY=1.
  - No pending strobe emerges after release.
